// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one pipelined CORDIC cosine core among NREQ requesters.
// Define CORDIC_SCHED_STATS_EN to add the grant/stall counters and their stat_* ports.
module cordic_sched #(
  parameter int NREQ       = 4,
  parameter int LAT        = 34,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [32*NREQ-1:0]      req_theta,
  input  logic                    cfg_valid,
  input  logic [5:0]              cfg_n,
  output logic                    cfg_ready,
  output logic [31:0]             cordic_theta,
  output logic [5:0]              cordic_n,
  input  logic [31:0]             cordic_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
`ifdef CORDIC_SCHED_STATS_EN
  input  logic                    stat_clear,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_stall,
`endif
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(LAT + FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] grant;
  logic           gnt_found;
  logic           issue_ok;
  logic           issue;
  logic           push;
  logic           pop;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [LAT-1:0] tag_vld_p;
  logic [IDW-1:0] tag_id_p [LAT];
  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic [IDW-1:0] fifo_id [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [31:0]    last_data;
  logic [IDW-1:0] last_id;

  function automatic logic [5:0] clamp_n(input logic [5:0] n);
    return (n > 6'd32) ? 6'd32 : n;
  endfunction

  // Issue stage: credit check and round-robin search starting just above rr
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && req_valid[j] && (j > int'(rr))) begin
        gnt_found = 1'b1;
        grant     = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!gnt_found && req_valid[j] && (j <= int'(rr))) begin
        gnt_found = 1'b1;
        grant     = IDW'(j);
      end
    end
  end

  assign issue_ok = (state == RUN) && !cfg_valid && ((inflight + fifo_count) < CW'(FIFO_DEPTH));
  assign issue    = issue_ok && gnt_found;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant] = 1'b1;
  end

  assign cordic_theta = issue ? req_theta[{grant, 5'd0} +: 32] : 32'd0;

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    case (state)
      RUN:     if (cfg_valid) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = APPLY;
      APPLY: begin
        cfg_ready = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Capture stage: tag leaving the pipeline pairs with the core result
  assign push      = tag_vld_p[LAT-1];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : last_data;
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : last_id;
  assign busy      = (inflight != '0) || rsp_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      cordic_n   <= 6'd32;
      rr         <= IDW'(NREQ - 1);
      tag_vld_p  <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_data  <= '0;
      last_id    <= '0;
    end else begin
      state     <= state_nxt;
      tag_vld_p <= {tag_vld_p[LAT-2:0], issue};
      if (state == APPLY) cordic_n <= clamp_n(cfg_n);
      if (issue) rr <= grant;
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_data <= fifo_data[rd_ptr];
        last_id   <= fifo_id[rd_ptr];
      end
    end
  end

  // Data path: tag ids and FIFO storage carry no reset, validity lives in the control state
  always_ff @(posedge clk) begin
    tag_id_p[0] <= grant;
    for (int k = 1; k < LAT; k++) tag_id_p[k] <= tag_id_p[k-1];
    if (push) begin
      fifo_data[wr_ptr] <= cordic_result;
      fifo_id[wr_ptr]   <= tag_id_p[LAT-1];
    end
  end

`ifdef CORDIC_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else if (stat_clear) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && (stat_issued != 32'hFFFF_FFFF)) stat_issued <= stat_issued + 1'b1;
      if ((|req_valid) && !issue && (stat_stall != 32'hFFFF_FFFF)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

  // Credits bound inflight + fifo_count, so the FIFO can never overflow
  assert property (@(posedge clk) disable iff (!reset) fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_cordic_sched.sv
// tb_cordic_sched: scoreboard bench for cordic_sched with a behavioural fp32 CORDIC core.
module tb_cordic_sched;
  localparam int NREQ       = 4;
  localparam int LAT        = 34;
  localparam int FIFO_DEPTH = 8;
  localparam real K_INV     = 0.6072529350088812561694;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_theta;
  logic                 cfg_valid;
  logic [5:0]           cfg_n;
  logic                 cfg_ready;
  logic [31:0]          cordic_theta;
  logic [5:0]           cordic_n;
  logic [31:0]          cordic_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [1:0]           rsp_id;
  logic                 busy;
`ifdef CORDIC_SCHED_STATS_EN
  logic                 stat_clear = 1'b0;
  logic [31:0]          stat_issued;
  logic [31:0]          stat_stall;
`endif

  typedef struct packed { logic [1:0] id; logic [31:0] data; } exp_t;
  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [5:0] tb_n   = 6'd32;
  logic [31:0] core_pipe [LAT];

  always #5 clk = ~clk;

  cordic_sched #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_theta(req_theta),
    .cfg_valid(cfg_valid), .cfg_n(cfg_n), .cfg_ready(cfg_ready),
    .cordic_theta(cordic_theta), .cordic_n(cordic_n), .cordic_result(cordic_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef CORDIC_SCHED_STATS_EN
    .stat_clear(stat_clear), .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
    .busy(busy)
  );

  function automatic real fp_to_real(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * $pow(2.0, real'(int'(b[30:23]) - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] real_to_fp(input real x);
    real    a;
    int     e;
    longint m;
    if (x == 0.0) return 32'd0;
    a = (x < 0.0) ? -x : x;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = longint'((a - 1.0) * 8388608.0);
    if (m >= 64'd8388608) begin m = 0; e++; end
    return {(x < 0.0), 8'(e + 127), 23'(m)};
  endfunction

  function automatic logic [31:0] cordic_model(input logic [31:0] th, input logic [5:0] n);
    real x, y, z, xn, p;
    int  it;
    x  = K_INV;
    y  = 0.0;
    z  = fp_to_real(th);
    p  = 1.0;
    it = (n > 6'd32) ? 32 : int'(n);
    for (int i = 0; i < it; i++) begin
      if (z >= 0.0) begin xn = x - y * p; y = y + x * p; z = z - $atan(p); end
      else          begin xn = x + y * p; y = y - x * p; z = z + $atan(p); end
      x = xn;
      p = p / 2.0;
    end
    return real_to_fp(x);
  endfunction

  function automatic int ulp_diff(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  // Behavioural core: LAT-cycle pipeline from theta/n to result
  always @(posedge clk) begin
    core_pipe[0] <= cordic_model(cordic_theta, cordic_n);
    for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign cordic_result = core_pipe[LAT-1];

  // Scoreboard: accepted requests pushed, responses popped on the handshake
  always @(negedge clk) begin
    exp_t e;
    if (!reset) sb.delete();
    else begin
      for (int k = 0; k < NREQ; k++)
        if (req_ready[k]) sb.push_back({2'(k), cordic_model(req_theta[32*k +: 32], tb_n)});
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rsp: got id=%0d data=%h, required no response", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((busy || sb.size() != 0) && c < 400) begin tick(); sample(); c++; end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%0b pending=%0d, required busy=0 pending=0", name, busy, sb.size());
    end
  endtask

  task automatic wait_cfg(output int cyc);
    cyc = 0;
    while (cfg_ready !== 1'b1 && cyc < 200) begin tick(); sample(); cyc++; end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready_timeout: got cfg_ready=%0b after %0d cycles, required 1", cfg_ready, cyc);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_theta = {32'h3F400000, 32'h3F000000, 32'h3E4CCCCD, 32'h3DCCCCCD};
    cfg_valid = 1'b0;
    cfg_n     = 6'd32;
    rsp_ready = 1'b1;
    repeat (3) sample();
    checks += 8;
    if (req_ready !== '0)          begin errors++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
    if (cfg_ready !== 1'b0)        begin errors++; $display("FAIL rst_cfg_ready: got %0b, required 0", cfg_ready); end
    if (rsp_valid !== 1'b0)        begin errors++; $display("FAIL rst_rsp_valid: got %0b, required 0", rsp_valid); end
    if (rsp_data !== 32'd0)        begin errors++; $display("FAIL rst_rsp_data: got %h, required 0", rsp_data); end
    if (rsp_id !== 2'd0)           begin errors++; $display("FAIL rst_rsp_id: got %0d, required 0", rsp_id); end
    if (busy !== 1'b0)             begin errors++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    if (cordic_n !== 6'd32)        begin errors++; $display("FAIL rst_cordic_n: got %0d, required 32", cordic_n); end
    if (cordic_theta !== 32'd0)    begin errors++; $display("FAIL rst_cordic_theta: got %h, required 0", cordic_theta); end
    tick();
    reset = 1'b1;
    sample();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp;
    tick();
    req_valid = 4'hF;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      sample();
      exp = (i < FIFO_DEPTH) ? (NREQ'(1) << (i % NREQ)) : '0;
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b, required %b", i, req_ready, exp);
      end
      tick();
    end
    req_valid = '0;
    sample();
    wait_idle("rr");
  endtask

  task automatic test_single();
    int          first;
    logic [1:0]  got_id;
    logic [31:0] got_data;
    tick();
    req_valid = 4'b0100;
    sample();
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_accept: got %b, required 0100", req_ready); end
    tick();
    req_valid = '0;
    first     = -1;
    got_id    = '0;
    got_data  = '0;
    for (int c = 1; c <= LAT + 3; c++) begin
      sample();
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b, required 1", busy); end
      end
      if (rsp_valid && first < 0) begin first = c; got_id = rsp_id; got_data = rsp_data; end
      tick();
    end
    sample();
    checks += 3;
    if (first != LAT + 1)  begin errors++; $display("FAIL single_latency: got %0d, required %0d", first, LAT + 1); end
    if (got_id !== 2'd2)   begin errors++; $display("FAIL single_id: got %0d, required 2", got_id); end
    if (ulp_diff(got_data, 32'h3F60A940) > 1) begin
      errors++; $display("FAIL single_cos: got %h, required 3f60a940 +-1ulp", got_data);
    end
    wait_idle("single");
  endtask

  task automatic test_back_pressure();
    int grants;
    grants = 0;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < LAT + 12; c++) begin
      sample();
      if (req_ready != '0) grants++;
      tick();
    end
    sample();
    checks += 3;
    if (grants != FIFO_DEPTH) begin errors++; $display("FAIL bp_grants: got %0d, required %0d", grants, FIFO_DEPTH); end
    if (req_ready !== '0)     begin errors++; $display("FAIL bp_full_ready: got %b, required 0000", req_ready); end
    if (rsp_valid !== 1'b1)   begin errors++; $display("FAIL bp_rsp_valid: got %0b, required 1", rsp_valid); end
    tick();
    rsp_ready = 1'b1;
    sample();
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_pop_cycle_ready: got %b, required 0000", req_ready); end
    tick();
    rsp_ready = 1'b0;
    sample();
    checks++;
    if (!$onehot(req_ready)) begin errors++; $display("FAIL bp_one_more: got %b, required one-hot", req_ready); end
    tick();
    sample();
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL bp_after_one: got %b, required 0000", req_ready); end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    sample();
    wait_idle("bp");
  endtask

  task automatic test_config_drain();
    int cyc;
    int leak;
    tick();
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin sample(); tick(); end
    cfg_valid = 1'b1;
    cfg_n     = 6'd8;
    sample();
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL drain_cfg_cycle: got %b, required 0000", req_ready); end
    cyc  = 0;
    leak = 0;
    while (cfg_ready !== 1'b1 && cyc < 200) begin
      tick();
      sample();
      cyc++;
      if (req_ready != '0) leak++;
    end
    checks += 3;
    if (cyc != LAT + 1) begin errors++; $display("FAIL drain_cycles: got %0d, required %0d", cyc, LAT + 1); end
    if (leak != 0)      begin errors++; $display("FAIL drain_leak: got %0d grants, required 0", leak); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL drain_busy_at_apply: got %0b, required 0", busy); end
    tb_n = 6'd8;
    tick();
    cfg_valid = 1'b0;
    sample();
    checks += 2;
    if (cordic_n !== 6'd8)   begin errors++; $display("FAIL drain_cordic_n: got %0d, required 8", cordic_n); end
    if (!$onehot(req_ready)) begin errors++; $display("FAIL drain_resume: got %b, required one-hot", req_ready); end
    tick();
    req_valid = '0;
    sample();
    wait_idle("drain");
  endtask

  task automatic test_clamp_zero();
    int cyc;
    int c;
    tick();
    cfg_valid = 1'b1;
    cfg_n     = 6'd40;
    sample();
    wait_cfg(cyc);
    tb_n = 6'd32;
    tick();
    cfg_valid = 1'b0;
    sample();
    checks++;
    if (cordic_n !== 6'd32) begin errors++; $display("FAIL clamp_n40: got %0d, required 32", cordic_n); end
    tick();
    cfg_valid = 1'b1;
    cfg_n     = 6'd0;
    sample();
    wait_cfg(cyc);
    tb_n = 6'd0;
    tick();
    cfg_valid = 1'b0;
    req_theta[63:32] = 32'h3F800000;
    req_valid = 4'b0010;
    sample();
    checks += 2;
    if (cordic_n !== 6'd0)     begin errors++; $display("FAIL zero_n: got %0d, required 0", cordic_n); end
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_accept: got %b, required 0010", req_ready); end
    tick();
    req_valid = '0;
    sample();
    c = 0;
    while (!rsp_valid && c < LAT + 5) begin tick(); sample(); c++; end
    checks += 2;
    if (rsp_valid !== 1'b1 || ulp_diff(rsp_data, 32'h3F1B74EE) > 1) begin
      errors++; $display("FAIL zero_result: got valid=%0b data=%h, required 3f1b74ee +-1ulp", rsp_valid, rsp_data);
    end
    if (rsp_id !== 2'd1) begin errors++; $display("FAIL zero_id: got %0d, required 1", rsp_id); end
    wait_idle("zero");
    tick();
    req_theta[63:32] = 32'h3E4CCCCD;
    cfg_valid = 1'b1;
    cfg_n     = 6'd32;
    sample();
    wait_cfg(cyc);
    tb_n = 6'd32;
    tick();
    cfg_valid = 1'b0;
    sample();
  endtask

  task automatic test_reset_midflight();
    int seen;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin sample(); tick(); end
    req_valid = '0;
    for (int i = 0; i < LAT + 2; i++) begin sample(); tick(); end
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin sample(); tick(); end
    req_valid = '0;
    sample();
    checks += 2;
    if (busy !== 1'b1)      begin errors++; $display("FAIL mid_busy_before: got %0b, required 1", busy); end
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_rsp_before: got %0b, required 1", rsp_valid); end
    tick();
    reset = 1'b0;
    sample();
    tick();
    sample();
    checks += 2;
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy_in_reset: got %0b, required 0", busy); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_in_reset: got %0b, required 0", rsp_valid); end
    tick();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      sample();
      if (rsp_valid) seen++;
      tick();
    end
    req_valid = 4'hF;
    sample();
    checks += 3;
    if (seen != 0)             begin errors++; $display("FAIL mid_stale_rsp: got %0d, required 0", seen); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL mid_busy_after: got %0b, required 0", busy); end
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_reset: got %b, required 0001", req_ready); end
    tick();
    req_valid = '0;
    sample();
    wait_idle("mid");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_back_pressure();
    test_config_drain();
    test_clamp_zero();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
